matrix_packetiser: RTL and testbench
====================================

// Module: matrix_packetiser
// PURPOSE
// Downstream consumer of the PicoRV32 system's matrix MMIO outputs: tags each 32-bit matrix word with
// destination/row/column and queues it as a flit toward the NoC router. Buffers bursts in a FIFO,
// emits an END flit per matrix, and reports overflow so firmware stores are never back-pressured.
// PARAMETERS
// FIFO_DEPTH    16     flit entries; power of two, >=2
// ROW_WIDTH     8      row index width
// COL_WIDTH     8      column index width
// DEFAULT_DEST  8'h00  destination {y[7:4],x[3:0]} after reset
// PORTS
// clk               in   1       system clock
// reset             in   1       asynchronous, active-high reset
// in_matrix         in   32      matrix word (system out_matrix)
// in_matrix_en      in   1       1-cycle word strobe
// in_matrix_end_row in   1       1-cycle end-of-row strobe
// in_matrix_end     in   1       1-cycle end-of-matrix strobe
// in_position       in   8       destination {y,x}
// in_position_en    in   1       1-cycle destination strobe
// pkt_flit          out  42+R+C {type[1:0],dest[7:0],row,col,data[31:0]}
// pkt_valid         out  1       flit valid
// pkt_ready         in   1       downstream accepts
// fifo_level        out  log2(FIFO_DEPTH)+1  entries held
// overflow          out  1       sticky: a flit was dropped
// drop_count        out  16      dropped flits, saturating
// BEHAVIOUR
// - Reset (async, any time incl. mid-packet): pkt_valid=0, pkt_flit=0, FIFO empty, fifo_level=0,
//   overflow=0, drop_count=0, dest=DEFAULT_DEST, row=col=0, word_count=0, end_pending=0.
// - Flit types: 2'b01 DATA (data=word), 2'b10 END (data=word_count of matrix, row/col=final values).
// - in_position_en: dest<=in_position; same-cycle in_matrix_en word already uses the new dest.
// - in_matrix_en: push DATA flit {dest,row,col,word}; col<=col+1 (wraps mod 2^COL_WIDTH);
//   word_count<=word_count+1 (32-bit, wraps).
// - in_matrix_end_row: row<=row+1 (wraps), col<=0; same-cycle word uses the pre-increment row/col.
// - in_matrix_end: end_pending<=1, with snapshot of dest/row/col/word_count including a same-cycle word;
//   then row, col, word_count<=0; same-cycle end_row is ignored.
// - Push arbiter, one push per cycle: DATA word beats pending END; END pushes first free cycle, then
//   end_pending<=0. New in_matrix_end while pending: overwrite snapshot, count one drop, set overflow.
// - FIFO full on push with no same-cycle pop: flit dropped, overflow<=1, drop_count++ (sat 16'hFFFF).
//   Push when full with same-cycle pop succeeds; level unchanged.
// - Output: show-ahead FIFO; pkt_valid=(level!=0), pkt_flit=head. Pop when pkt_valid&&pkt_ready.
//   While valid&&!ready, pkt_flit stays stable. Push into empty FIFO: pkt_valid in the next cycle
//   (1-cycle latency). Pointers wrap mod FIFO_DEPTH.
// - overflow and drop_count clear only on reset.
// TESTING
// - Reset, pos 8'h21, words A0..A3, end_row, B0, end -> DATA row0 col0..3, DATA row1 col0;
//   END data=5 dest 8'h21.
// - pkt_ready=0, FIFO_DEPTH+3 words -> level=FIFO_DEPTH, overflow=1, drop_count=3; first
//   FIFO_DEPTH words drain in order.
// - Word+end same cycle -> DATA then END on consecutive pushes; END data includes the word.
// - Full FIFO, push+pop same cycle -> no drop, level stays FIFO_DEPTH, order preserved.
// - Position+word same cycle -> flit dest = new position; pkt_ready toggled -> flit stable while stalled.
// - Reset mid-burst with flits queued -> pkt_valid=0 immediately; level 0; next word row0 col0.

Source files
------------

// File: rtl/matrix_packetiser_if.sv
// Flit stream from the matrix packetiser toward the NoC router.
// The master drives flits and valid. The slave answers with ready.
interface matrix_packetiser_if #(
   parameter int FLIT_WIDTH = 58
);
   logic [FLIT_WIDTH-1:0] pkt_flit;
   logic                  pkt_valid;
   logic                  pkt_ready;

   modport master (output pkt_flit, output pkt_valid, input  pkt_ready);
   modport slave  (input  pkt_flit, input  pkt_valid, output pkt_ready);
endinterface

// File: rtl/matrix_packetiser.sv
// Tags matrix MMIO words with dest/row/col and queues them as NoC flits.
// It also emits one END flit per matrix. Firmware is never back-pressured: a flit that finds the FIFO full is dropped and counted.
module matrix_packetiser #(
   parameter int         FIFO_DEPTH   = 16,
   parameter int         ROW_WIDTH    = 8,
   parameter int         COL_WIDTH    = 8,
   parameter logic [7:0] DEFAULT_DEST = 8'h00
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 in_matrix,
   input  logic                        in_matrix_en,
   input  logic                        in_matrix_end_row,
   input  logic                        in_matrix_end,
   input  logic [7:0]                  in_position,
   input  logic                        in_position_en,
   matrix_packetiser_if.master         pkt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic [15:0]                 drop_count
);
   localparam int FLIT_WIDTH = 42 + ROW_WIDTH + COL_WIDTH;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam logic [1:0] TYPE_DATA = 2'b01;
   localparam logic [1:0] TYPE_END  = 2'b10;

   logic [7:0]            dest;
   logic [ROW_WIDTH-1:0]  row;
   logic [COL_WIDTH-1:0]  col;
   logic [31:0]           word_count;
   logic                  end_pending;
   logic [FLIT_WIDTH-1:0] end_flit;

   logic [7:0]            cur_dest;
   logic [COL_WIDTH-1:0]  next_col;
   logic [31:0]           next_count;
   logic                  push_req;
   logic [FLIT_WIDTH-1:0] push_flit;
   logic                  end_taken;
   logic                  end_overwrite;
   logic                  fifo_full;
   logic                  fifo_valid;
   logic                  pop;
   logic                  push_ok;
   logic                  push_drop;
   logic [1:0]            drop_inc;
   logic [16:0]           drop_sum;

   logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           level;

   // A data word always wins the single push slot; a pending END waits for a word-free cycle
   always_comb begin
      cur_dest      = in_position_en ? in_position : dest;
      next_col      = col + COL_WIDTH'(in_matrix_en);
      next_count    = word_count + 32'(in_matrix_en);
      push_req      = 1'b0;
      push_flit     = end_flit;
      end_taken     = 1'b0;
      if (in_matrix_en) begin
         push_req  = 1'b1;
         push_flit = {TYPE_DATA, cur_dest, row, col, in_matrix};
      end else if (end_pending) begin
         push_req  = 1'b1;
         end_taken = 1'b1;
      end
      end_overwrite = in_matrix_end && end_pending && !end_taken;
      fifo_valid    = (level != '0);
      fifo_full     = (level == (AW+1)'(FIFO_DEPTH));
      pop           = fifo_valid && pkt.pkt_ready;
      push_ok       = push_req && (!fifo_full || pop);
      push_drop     = push_req && !push_ok;
      drop_inc      = {1'b0, push_drop} + {1'b0, end_overwrite};
      drop_sum      = {1'b0, drop_count} + {15'd0, drop_inc};
   end

   assign pkt.pkt_valid = fifo_valid;
   assign pkt.pkt_flit  = fifo_valid ? mem[rd_ptr] : '0;
   assign fifo_level    = level;

   // Matrix position tracking; the END snapshot already counts a same-cycle word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dest        <= DEFAULT_DEST;
         row         <= '0;
         col         <= '0;
         word_count  <= '0;
         end_pending <= 1'b0;
         end_flit    <= '0;
      end else begin
         dest <= cur_dest;
         if (in_matrix_end) begin
            row         <= '0;
            col         <= '0;
            word_count  <= '0;
            end_pending <= 1'b1;
            end_flit    <= {TYPE_END, cur_dest, row, next_col, next_count};
         end else begin
            word_count <= next_count;
            if (in_matrix_end_row) begin
               row <= row + ROW_WIDTH'(1);
               col <= '0;
            end else begin
               col <= next_col;
            end
            if (end_taken)
               end_pending <= 1'b0;
         end
      end
   end

   // FIFO pointers plus the sticky drop bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         if (drop_inc != 2'd0)
            overflow <= 1'b1;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_flit;
   end
endmodule

// File: tb/tb_matrix_packetiser.sv
// Self-checking bench for matrix_packetiser.
// It uses a stimulus table, hand-written corner sequences and a queue-based reference model.
module tb_matrix_packetiser;
   localparam int DEPTH = 16;
   localparam int FW    = 58;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_matrix = '0;
   logic        in_matrix_en = 1'b0;
   logic        in_matrix_end_row = 1'b0;
   logic        in_matrix_end = 1'b0;
   logic [7:0]  in_position = '0;
   logic        in_position_en = 1'b0;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic [15:0] drop_count;

   matrix_packetiser_if #(.FLIT_WIDTH(FW)) pkt_if ();

   matrix_packetiser #(.FIFO_DEPTH(DEPTH), .ROW_WIDTH(8), .COL_WIDTH(8), .DEFAULT_DEST(8'h00)) dut (
      .clk(clk), .reset(reset), .in_matrix(in_matrix), .in_matrix_en(in_matrix_en),
      .in_matrix_end_row(in_matrix_end_row), .in_matrix_end(in_matrix_end),
      .in_position(in_position), .in_position_en(in_position_en), .pkt(pkt_if),
      .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [FW-1:0] exp_q [$];
   logic [7:0]    m_dest;
   logic [7:0]    m_row;
   logic [7:0]    m_col;
   logic [31:0]   m_count;
   bit            m_pend;
   logic [FW-1:0] m_snap;
   bit            m_over;
   int            m_drops;

   typedef struct {
      logic        en;
      logic [31:0] word;
      logic        end_row;
      logic        end_m;
      logic        pos_en;
      logic [7:0]  pos;
      logic        rdy;
      logic        exp_valid;
      logic [4:0]  exp_level;
      logic [FW-1:0] exp_flit;
   } vec_t;
   vec_t tbl [10];

   function automatic logic [FW-1:0] mkflit(input logic [1:0] t, input logic [7:0] d,
                                            input logic [7:0] r, input logic [7:0] c,
                                            input logic [31:0] x);
      return {t, d, r, c, x};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      exp_q.delete();
      m_dest  = 8'h00;
      m_row   = '0;
      m_col   = '0;
      m_count = '0;
      m_pend  = 1'b0;
      m_snap  = '0;
      m_over  = 1'b0;
      m_drops = 0;
   endtask

   // One clock of stimulus; the model advances by the spec's rules, then we sit 1ns past the edge
   task automatic applyStimulus(input logic en, input logic [31:0] w, input logic er, input logic e,
                                input logic pe, input logic [7:0] p, input logic rdy);
      logic [7:0]    d;
      logic [7:0]    ecol;
      logic [FW-1:0] f;
      bit            old_pend;
      bit            has_push;
      in_matrix         = w;
      in_matrix_en      = en;
      in_matrix_end_row = er;
      in_matrix_end     = e;
      in_position       = p;
      in_position_en    = pe;
      pkt_if.pkt_ready  = rdy;
      d        = pe ? p : m_dest;
      old_pend = m_pend;
      has_push = 1'b0;
      f        = '0;
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (en) begin
         f = mkflit(2'b01, d, m_row, m_col, w);
         has_push = 1'b1;
      end else if (old_pend) begin
         f = m_snap;
         has_push = 1'b1;
         m_pend = 1'b0;
      end
      if (has_push) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(f);
         else begin m_drops++; m_over = 1'b1; end
      end
      if (e) begin
         if (old_pend && en) begin m_drops++; m_over = 1'b1; end
         ecol   = m_col + 8'(en);
         m_snap = mkflit(2'b10, d, m_row, ecol, m_count + 32'(en));
         m_pend = 1'b1;
         m_row = '0; m_col = '0; m_count = '0;
      end else begin
         m_count = m_count + 32'(en);
         if (er) begin m_row = m_row + 8'd1; m_col = '0; end
         else if (en) m_col = m_col + 8'd1;
      end
      m_dest = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, rdy);
   endtask

   task automatic checkOutput(input string tag);
      logic [FW-1:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check($sformatf("%s.valid", tag), 64'(pkt_if.pkt_valid), 64'(exp_q.size() > 0));
      check($sformatf("%s.level", tag), 64'(fifo_level), 64'(exp_q.size()));
      check($sformatf("%s.flit", tag), 64'(pkt_if.pkt_flit), 64'(head));
      check($sformatf("%s.overflow", tag), 64'(overflow), 64'(m_over));
      check($sformatf("%s.drops", tag), 64'(drop_count), 64'((m_drops > 65535) ? 65535 : m_drops));
   endtask

   task automatic doReset();
      reset = 1'b1;
      in_matrix_en = 1'b0; in_matrix_end_row = 1'b0; in_matrix_end = 1'b0; in_position_en = 1'b0;
      pkt_if.pkt_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
      checkOutput("reset");
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit reached, expected run to have finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [FW-1:0] held;
      pkt_if.pkt_ready = 1'b0;
      modelReset();
      #2;
      doReset();

      // Basic matrix: position, four words, end_row, one word, end
      tbl[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 5'd0, '0};
      tbl[1] = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b01, 8'h21, 8'd0, 8'd0, 32'hA0)};
      tbl[2] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b01, 8'h21, 8'd0, 8'd1, 32'hA1)};
      tbl[3] = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b01, 8'h21, 8'd0, 8'd2, 32'hA2)};
      tbl[4] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b01, 8'h21, 8'd0, 8'd3, 32'hA3)};
      tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, '0};
      tbl[6] = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b01, 8'h21, 8'd1, 8'd0, 32'hB0)};
      tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, '0};
      tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, mkflit(2'b10, 8'h21, 8'd1, 8'd1, 32'd5)};
      tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, '0};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].en, tbl[i].word, tbl[i].end_row, tbl[i].end_m, tbl[i].pos_en, tbl[i].pos, tbl[i].rdy);
         check($sformatf("tbl%0d.valid", i), 64'(pkt_if.pkt_valid), 64'(tbl[i].exp_valid));
         check($sformatf("tbl%0d.level", i), 64'(fifo_level), 64'(tbl[i].exp_level));
         check($sformatf("tbl%0d.flit", i), 64'(pkt_if.pkt_flit), 64'(tbl[i].exp_flit));
      end

      // Overflow: DEPTH+3 words against a stalled router, then drain in order
      doReset();
      for (int i = 0; i < DEPTH + 3; i++) applyStimulus(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("ovf");
      check("ovf.level_const", 64'(fifo_level), 64'(DEPTH));
      check("ovf.flag_const", 64'(overflow), 64'd1);
      check("ovf.drops_const", 64'(drop_count), 64'd3);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("drain%0d.data", i), 64'(pkt_if.pkt_flit[31:0]), 64'(32'hC000_0000 + i));
         check($sformatf("drain%0d.col", i), 64'(pkt_if.pkt_flit[39:32]), 64'(i));
         idle(1'b1);
      end
      checkOutput("drained");

      // Word and end in the same cycle: DATA then END, END count includes the word
      doReset();
      applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 32'hD1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      idle(1'b0);
      checkOutput("wend");
      check("wend.level", 64'(fifo_level), 64'd3);
      idle(1'b1);
      idle(1'b1);
      check("wend.end", 64'(pkt_if.pkt_flit), 64'(mkflit(2'b10, 8'h00, 8'd0, 8'd2, 32'd2)));

      // Full FIFO with simultaneous push and pop: no drop, level stays full
      doReset();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'hE0 + i, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 32'hEEEE, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("fullpp");
      check("fullpp.level", 64'(fifo_level), 64'(DEPTH));
      check("fullpp.drops", 64'(drop_count), 64'd0);
      check("fullpp.head", 64'(pkt_if.pkt_flit[31:0]), 64'h0E1);

      // Position with word in the same cycle, then a stall must keep the head stable
      doReset();
      applyStimulus(1'b1, 32'hF0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
      check("pos.dest", 64'(pkt_if.pkt_flit[55:48]), 64'h5A);
      applyStimulus(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      held = pkt_if.pkt_flit;
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         check($sformatf("stall%0d", i), 64'(pkt_if.pkt_flit), 64'(held));
      end
      idle(1'b1);
      checkOutput("unstall");
      check("unstall.data", 64'(pkt_if.pkt_flit[31:0]), 64'hF1);

      // Asynchronous reset mid-burst clears the queue before any clock edge
      doReset();
      applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      #2;
      reset = 1'b1;
      in_matrix_en = 1'b0;
      #1;
      check("arst.valid", 64'(pkt_if.pkt_valid), 64'd0);
      check("arst.level", 64'(fifo_level), 64'd0);
      check("arst.flit", 64'(pkt_if.pkt_flit), 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      check("arst.next", 64'(pkt_if.pkt_flit), 64'(mkflit(2'b01, 8'h00, 8'd0, 8'd0, 32'h13)));

      // Randomised traffic against the reference model
      doReset();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 9) < 4), $urandom, ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                       8'($urandom), ($urandom_range(0, 9) < 4));
         checkOutput("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
